// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display capture block.
// Holds the FSM state type, segment patterns and the digit index helper.
package seven_seg_pkg;

    localparam int DIGITS = 8;
    localparam int SEG_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F = 7'h47;

    function automatic logic [2:0] digit_index(input logic [DIGITS-1:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_capture_seg_decode.sv
// Segment pattern to hex nibble decoder.
// Any pattern outside the 16-entry table reports valid = 0.
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        unique case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a multiplexed seven-segment display drive.
// A digit is captured once per scan period after it has been stable.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS-1:0]   an,
    input  logic [SEG_W-1:0]    seg,
    input  logic                dp,
    input  logic                clear,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   digit_valid,
    output logic [DIGITS-1:0]   dp_out,
    output logic                frame_done,
    output logic                err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [DIGITS-1:0] an_r;
    logic [SEG_W-1:0]  seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] samp_an;
    logic [SEG_W-1:0]  samp_seg;
    logic              samp_dp;
    logic [7:0]        cnt;
    logic [7:0]        cnt_d;
    state_t            state_q;
    state_t            state_d;

    logic              onehot;
    logic              same;
    logic              start;
    logic              capture;
    logic [2:0]        idx;
    logic [3:0]        nib;
    logic              nib_ok;
    logic [DIGITS-1:0] dv_next;
    logic [DIGITS-1:0] an_n;

    assign an_n   = ~an_r;
    assign onehot = (an_n != '0) && ((an_n & (an_n - 1'b1)) == '0);
    assign same   = {an_r, seg_r, dp_r} == {samp_an, samp_seg, samp_dp};
    assign idx    = digit_index(an_r);

    seg_decode u_dec (
        .seg    (seg_r),
        .nibble (nib),
        .valid  (nib_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= '1;
            seg_r <= '0;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an;
            seg_r <= seg;
            dp_r  <= dp;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        start   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: start = onehot;
            SETTLE: begin
                if (same) begin
                    cnt_d = cnt + 8'd1;
                    if (cnt_d == STABLE) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (onehot) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!same && onehot) begin
                    start = 1'b1;
                end else if (!same) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new sample restarts the count; one-cycle stability captures at once.
        if (start) begin
            cnt_d = 8'd1;
            if (STABLE == 8'd1) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt      <= '0;
            samp_an  <= '1;
            samp_seg <= '0;
            samp_dp  <= 1'b1;
        end else if (clear) begin
            state_q  <= IDLE;
            cnt      <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            if (start) begin
                samp_an  <= an_r;
                samp_seg <= seg_r;
                samp_dp  <= dp_r;
            end
        end
    end

    always_comb begin
        dv_next = digit_valid;
        if (capture) dv_next[idx] = nib_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            digit_valid <= '0;
            dp_out      <= '1;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else if (clear) begin
            value       <= '0;
            digit_valid <= '0;
            dp_out      <= '1;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            digit_valid <= dv_next;
            frame_done  <= (digit_valid != '1) && (dv_next == '1);
            if (capture) begin
                dp_out[idx] <= dp_r;
                if (nib_ok) value[4*idx +: 4] <= nib;
                else        err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench: a run-length model predicts outputs every cycle.
// A separate monitor pops predictions on the falling edge and compares.
module tb_seven_seg_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        clear;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic [7:0]  dp_out;
    logic        frame_done;
    logic        err;

    seven_seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .clear       (clear),
        .value       (value),
        .digit_valid (digit_valid),
        .dp_out      (dp_out),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dv;
        logic [7:0]  dpo;
        logic        fd;
        logic        err;
    } snap_t;

    logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                              7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                              7'h4E, 7'h3D, 7'h4F, 7'h47};

    snap_t       q[$];
    snap_t       m;
    logic [15:0] prev_pin;
    logic [15:0] last;
    int          run;
    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (pats[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m        = '{value: 32'h0, dv: 8'h00, dpo: 8'hFF, fd: 1'b0, err: 1'b0};
        prev_pin = {8'hFF, 7'h00, 1'b1};
        last     = '0;
        run      = 0;
    endtask

    // The sample seen at an edge is the pin value from the previous cycle.
    task automatic model_edge(input logic [15:0] pin, input logic clr);
        logic [15:0] smp;
        logic [7:0]  old_dv;
        bit          oh;
        int          d;
        int          k;
        smp = prev_pin;
        oh  = $countones(~smp[15:8]) == 1;
        if (smp == last && run > 0) run++;
        else run = oh ? 1 : 0;
        last = smp;
        m.fd = 1'b0;
        if (clr) begin
            m   = '{value: 32'h0, dv: 8'h00, dpo: 8'hFF, fd: 1'b0, err: 1'b0};
            run = 0;
        end else if (oh && run == S) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (!smp[8+i]) k = i;
            d      = decode(smp[7:1]);
            old_dv = m.dv;
            if (d >= 0) begin
                m.value[4*k +: 4] = 4'(d);
                m.dv[k] = 1'b1;
            end else begin
                m.dv[k] = 1'b0;
                m.err   = 1'b1;
            end
            m.dpo[k] = smp[0];
            m.fd = (old_dv != 8'hFF) && (m.dv == 8'hFF);
        end
        prev_pin = pin;
    endtask

    task automatic step(input logic [7:0] a, input logic [6:0] s,
                        input logic d, input logic c);
        an = a; seg = s; dp = d; clear = c;
        @(posedge clk);
        #1;
        model_edge({a, s, d}, c);
        q.push_back(m);
    endtask

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin : monitor
        snap_t exp_s;
        snap_t got_s;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_count++;
            if (q.size() > 0) begin
                exp_s = q.pop_front();
                got_s = {value, digit_valid, dp_out, frame_done, err};
                checks++;
                if (got_s !== exp_s) begin
                    errors++;
                    $display("FAIL sb got v=%h dv=%h dp=%h fd=%b e=%b want v=%h dv=%h dp=%h fd=%b e=%b",
                             got_s.value, got_s.dv, got_s.dpo, got_s.fd, got_s.err,
                             exp_s.value, exp_s.dv, exp_s.dpo, exp_s.fd, exp_s.err);
                end
            end
        end
    end

    initial begin
        logic [7:0] a;
        logic [6:0] s;
        logic       d;
        int         len;
        int         r;
        rst = 1'b1; clear = 1'b0; an = 8'hFF; seg = '0; dp = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {value, digit_valid, dp_out, frame_done, err},
            {32'h0, 8'h00, 8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        repeat (6) step(8'hFE, 7'h7E, 1'b1, 1'b0);
        chk("single_dig", {value[3:0], digit_valid, err}, {4'h0, 8'h01, 1'b0});
        repeat (3) step(8'hFF, 7'h00, 1'b1, 1'b0);

        step(8'hFF, 7'h00, 1'b1, 1'b1);
        @(negedge clk);
        fd_count = 0;
        for (int i = 0; i < 8; i++)
            repeat (4) step(~(8'h01 << i), pats[i+1], 1'b1, 1'b0);
        repeat (4) step(8'hFF, 7'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("scan_value", value, 32'h87654321);
        chk("frame_once", fd_count, 1);

        step(8'hFF, 7'h00, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++)
            step(8'hFB, (i % 4 < 2) ? 7'h30 : 7'h6D, 1'b1, 1'b0);
        chk("toggle_nocap", digit_valid[2], 1'b0);

        repeat (6) step(8'hEF, 7'h5B, 1'b0, 1'b0);
        repeat (6) step(8'hEF, 7'h00, 1'b1, 1'b0);
        chk("bad_pattern", {err, digit_valid[4], value[19:16], dp_out[4]},
            {1'b1, 1'b0, 4'h5, 1'b1});

        repeat (6) step(8'hFC, 7'h7E, 1'b0, 1'b0);
        chk("two_low", {digit_valid, dp_out}, {8'h00, 8'hFF});
        repeat (4) step(8'hFD, 7'h30, 1'b0, 1'b0);
        step(8'hFD, 7'h30, 1'b0, 1'b1);
        chk("clear_wins", {value, digit_valid, dp_out, frame_done, err},
            {32'h0, 8'h00, 8'hFF, 1'b0, 1'b0});
        repeat (3) step(8'hFF, 7'h00, 1'b1, 1'b0);

        repeat (6) step(8'hF7, 7'h79, 1'b1, 1'b0);
        repeat (2) step(8'hFE, 7'h33, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {value, digit_valid, dp_out, frame_done, err},
            {32'h0, 8'h00, 8'hFF, 1'b0, 1'b0});
        model_reset();
        an = 8'hFF; seg = '0; dp = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step(8'hFF, 7'h00, 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 85) a = ~(8'h01 << $urandom_range(0, 7));
            else if (r < 93) a = 8'hFF;
            else a = ~((8'h01 << $urandom_range(0, 3)) | 8'h10);
            s   = ($urandom_range(0, 99) < 85) ? pats[$urandom_range(0, 15)]
                                               : 7'($urandom);
            d   = 1'($urandom);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++)
                step(a, s, d, (j == 0) && ($urandom_range(0, 99) < 3));
        end
        repeat (2) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
